reorder_buffer: RTL and testbench

- Circular reorder buffer for the Tomasulo core; sits between dispatcher, CDB and register file.
- Allocates a tag per dispatched instruction, captures results from the CDB and retires entries in program order.
- Drives the register file commit interface (commit flag, rd, value, tag) and the global rollback flag on a branch mispredict.
- Serves one operand-forwarding query per source for the dispatcher.

---
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 tb/tb_reorder_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tags dispatched instructions, captures CDB
// results, retires in program order and flushes on a branch mispredict.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             alloc_valid_in,
    input  logic [4:0]       alloc_rd_in,
    input  logic             alloc_is_branch_in,
    input  logic             alloc_pred_taken_in,
    output logic [TAG_W-1:0] alloc_tag_out,
    output logic             full_out,
    input  logic             wb_valid_in,
    input  logic [TAG_W-1:0] wb_tag_in,
    input  logic [31:0]      wb_value_in,
    input  logic             wb_taken_in,
    input  logic [31:0]      wb_target_in,
    input  logic [TAG_W-1:0] query1_tag_in,
    input  logic [TAG_W-1:0] query2_tag_in,
    output logic             ready1_out,
    output logic             ready2_out,
    output logic [31:0]      value1_out,
    output logic [31:0]      value2_out,
    output logic             commit_flag_out,
    output logic [4:0]       rd_out,
    output logic [31:0]      V_out,
    output logic [TAG_W-1:0] Q_out,
    output logic             rollback_flag_out,
    output logic [31:0]      redirect_pc_out
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [IW-1:0]    head;
    logic [IW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [4:0]       rd_q     [DEPTH];
    logic             br_q     [DEPTH];
    logic             pred_q   [DEPTH];
    logic             taken_q  [DEPTH];
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic          do_alloc;
    logic          do_wb;
    logic          do_commit;
    logic          mispredict;
    logic [IW-1:0] wb_idx;
    logic [IW-1:0] q1_idx;
    logic [IW-1:0] q2_idx;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (int'(t) <= DEPTH);
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [TAG_W-1:0] t);
        return IW'(t - TAG_W'(1));
    endfunction

    assign wb_idx = idx_of(wb_tag_in);
    assign q1_idx = idx_of(query1_tag_in);
    assign q2_idx = idx_of(query2_tag_in);

    assign full_out      = (count == CW'(DEPTH));
    assign alloc_tag_out = TAG_W'(tail) + TAG_W'(1);

    // Per-edge actions; rollback_flag_out doubles as the flush-in-progress state
    always_comb begin
        do_alloc   = rdy_in && !rollback_flag_out && alloc_valid_in && !full_out;
        do_wb      = rdy_in && !rollback_flag_out && wb_valid_in &&
                     tag_ok(wb_tag_in) && busy[wb_idx];
        do_commit  = rdy_in && !rollback_flag_out && busy[head] && ready[head];
        mispredict = do_commit && br_q[head] && (taken_q[head] != pred_q[head]);
    end

    // Operand forwarding for the dispatcher, no CDB bypass
    always_comb begin
        ready1_out = tag_ok(query1_tag_in) && busy[q1_idx] && ready[q1_idx];
        ready2_out = tag_ok(query2_tag_in) && busy[q2_idx] && ready[q2_idx];
        value1_out = ready1_out ? value_q[q1_idx] : '0;
        value2_out = ready2_out ? value_q[q2_idx] : '0;
    end

    // Pointers, status bits and registered commit/rollback outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            busy              <= '0;
            ready             <= '0;
            commit_flag_out   <= 1'b0;
            rd_out            <= '0;
            V_out             <= '0;
            Q_out             <= '0;
            rollback_flag_out <= 1'b0;
            redirect_pc_out   <= '0;
        end else if (rdy_in) begin
            if (rollback_flag_out) begin
                head              <= '0;
                tail              <= '0;
                count             <= '0;
                busy              <= '0;
                ready             <= '0;
                commit_flag_out   <= 1'b0;
                rollback_flag_out <= 1'b0;
            end else begin
                if (do_alloc) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + IW'(1);
                end
                if (do_wb) begin
                    ready[wb_idx] <= 1'b1;
                end
                if (do_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + IW'(1);
                    rd_out      <= rd_q[head];
                    V_out       <= value_q[head];
                    Q_out       <= TAG_W'(head) + TAG_W'(1);
                end
                if (do_alloc && !do_commit) begin
                    count <= count + CW'(1);
                end else if (!do_alloc && do_commit) begin
                    count <= count - CW'(1);
                end
                commit_flag_out   <= do_commit;
                rollback_flag_out <= mispredict;
                if (mispredict) begin
                    redirect_pc_out <= target_q[head];
                end
            end
        end
    end

    // Entry payload; only meaningful while the busy bit is set
    always_ff @(posedge clk_in) begin
        if (do_alloc) begin
            rd_q[tail]   <= alloc_rd_in;
            br_q[tail]   <= alloc_is_branch_in;
            pred_q[tail] <= alloc_pred_taken_in;
        end
        if (do_wb) begin
            value_q[wb_idx]  <= wb_value_in;
            taken_q[wb_idx]  <= wb_taken_in;
            target_q[wb_idx] <= wb_target_in;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random checks of reorder_buffer against a queue-based
// program-order model.
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rdy = 1'b1;
    logic             av = 1'b0;
    logic [4:0]       ard = '0;
    logic             abr = 1'b0;
    logic             apr = 1'b0;
    logic             wv = 1'b0;
    logic [TAG_W-1:0] wt = '0;
    logic [31:0]      wval = '0;
    logic             wtk = 1'b0;
    logic [31:0]      wtg = '0;
    logic [TAG_W-1:0] q1 = '0;
    logic [TAG_W-1:0] q2 = '0;

    logic [TAG_W-1:0] alloc_tag;
    logic             full;
    logic             r1, r2;
    logic [31:0]      v1, v2;
    logic             cflag;
    logic [4:0]       crd;
    logic [31:0]      cv;
    logic [TAG_W-1:0] cq;
    logic             rb;
    logic [31:0]      rpc;

    int n_vec = 0;
    int n_err = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .alloc_valid_in(av), .alloc_rd_in(ard),
        .alloc_is_branch_in(abr), .alloc_pred_taken_in(apr),
        .alloc_tag_out(alloc_tag), .full_out(full),
        .wb_valid_in(wv), .wb_tag_in(wt), .wb_value_in(wval),
        .wb_taken_in(wtk), .wb_target_in(wtg),
        .query1_tag_in(q1), .query2_tag_in(q2),
        .ready1_out(r1), .ready2_out(r2),
        .value1_out(v1), .value2_out(v2),
        .commit_flag_out(cflag), .rd_out(crd), .V_out(cv), .Q_out(cq),
        .rollback_flag_out(rb), .redirect_pc_out(rpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          br;
        bit          pred;
        bit          rdy;
        bit          tk;
        logic [31:0] val;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    int          m_next;
    bit          m_flush;
    bit          m_commit;
    logic [4:0]  m_rd;
    logic [31:0] m_v;
    int          m_q;
    bit          m_rb;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic bit mq_ready(input int t);
        foreach (mq[i]) if (mq[i].tag == t) return mq[i].rdy;
        return 0;
    endfunction

    function automatic logic [31:0] mq_val(input int t);
        foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) return mq[i].val;
        return 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_next = 1; m_flush = 0; m_commit = 0; m_rd = 0;
        m_v = 0; m_q = 0; m_rb = 0; m_pc = 0;
    endtask

    task automatic model_edge();
        bit   full_now, do_c, mis;
        ent_t h;
        if (!rdy) return;
        if (m_flush) begin
            mq.delete();
            m_next = 1; m_commit = 0; m_rb = 0; m_flush = 0;
            return;
        end
        full_now = (mq.size() == DEPTH);
        do_c = (mq.size() > 0) && mq[0].rdy;
        if (do_c) h = mq[0];
        if (wv && wt != 0) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(wt)) begin
                    mq[i].rdy = 1; mq[i].val = wval;
                    mq[i].tk = wtk; mq[i].tgt = wtg;
                end
            end
        end
        if (do_c) void'(mq.pop_front());
        if (av && !full_now) begin
            ent_t e;
            e.tag = m_next; e.rd = ard; e.br = abr; e.pred = apr;
            e.rdy = 0; e.tk = 0; e.val = 0; e.tgt = 0;
            mq.push_back(e);
            m_next = (m_next == DEPTH) ? 1 : m_next + 1;
        end
        m_commit = do_c;
        mis = do_c && h.br && (h.tk != h.pred);
        if (do_c) begin
            m_rd = h.rd; m_v = h.val; m_q = h.tag;
        end
        m_rb = mis;
        if (mis) m_pc = h.tgt;
        m_flush = mis;
    endtask

    task automatic check_all();
        chk("alloc_tag", 32'(alloc_tag), 32'(m_next));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("commit", 32'(cflag), 32'(m_commit));
        chk("rd", 32'(crd), 32'(m_rd));
        chk("V", cv, m_v);
        chk("Q", 32'(cq), 32'(m_q));
        chk("rollback", 32'(rb), 32'(m_rb));
        chk("redirect", rpc, m_pc);
        chk("ready1", 32'(r1), 32'(mq_ready(int'(q1))));
        chk("value1", v1, mq_val(int'(q1)));
        chk("ready2", 32'(r2), 32'(mq_ready(int'(q2))));
        chk("value2", v2, mq_val(int'(q2)));
    endtask

    task automatic idle();
        rdy = 1; av = 0; ard = 0; abr = 0; apr = 0;
        wv = 0; wt = 0; wval = 0; wtk = 0; wtg = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        idle();
        model_reset();
        #1;
        do_reset();

        // single alloc, writeback, commit
        av = 1; ard = 5; tick();
        chk("t1_tag2", 32'(alloc_tag), 32'd2);
        idle(); wv = 1; wt = 1; wval = 32'h1234; tick();
        idle(); tick();
        chk("t1_commit", 32'(cflag), 32'd1);
        chk("t1_V", cv, 32'h1234);
        chk("t1_Q", 32'(cq), 32'd1);
        tick();
        chk("t1_drop", 32'(cflag), 32'd0);

        // out-of-order writeback, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) begin
            av = 1; ard = 5'(i + 1); tick();
        end
        idle();
        for (int t = 3; t >= 1; t--) begin
            wv = 1; wt = TAG_W'(t); wval = 32'(t * 100); tick();
        end
        idle();
        for (int i = 0; i < 4; i++) tick();

        // fill, drop while full, wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            av = 1; ard = 5'(i); tick();
        end
        chk("t3_full", 32'(full), 32'd1);
        tick();
        chk("t3_full_hold", 32'(full), 32'd1);
        wv = 1; wt = 1; wval = 32'hAA; tick();
        wv = 0; tick();
        chk("t3_c", 32'(cflag), 32'd1);
        chk("t3_tag1", 32'(alloc_tag), 32'd1);
        tick();
        chk("t3_wrap", 32'(alloc_tag), 32'd2);

        // mispredict
        do_reset();
        idle(); av = 1; abr = 1; apr = 0; tick();
        abr = 0;
        for (int i = 0; i < 3; i++) tick();
        idle(); wv = 1; wt = 1; wtk = 1; wtg = 32'h100; tick();
        idle(); av = 1; tick();
        chk("t4_rb", 32'(rb), 32'd1);
        chk("t4_pc", rpc, 32'h100);
        chk("t4_c", 32'(cflag), 32'd1);
        wv = 1; wt = 3; wval = 32'h55; q1 = 3; tick();
        chk("t4_tag", 32'(alloc_tag), 32'd1);
        chk("t4_rb0", 32'(rb), 32'd0);
        idle(); tick();
        chk("t4_q3", 32'(r1), 32'd0);

        // query
        do_reset();
        q1 = 0; q2 = 2;
        av = 1; tick(); tick();
        idle(); tick();
        chk("t5_r0", 32'(r2), 32'd0);
        wv = 1; wt = 2; wval = 7; tick();
        idle();
        chk("t5_r1", 32'(r2), 32'd1);
        chk("t5_v7", v2, 32'd7);
        chk("t5_q0", 32'(r1), 32'd0);

        // stall with ready head
        do_reset();
        av = 1; ard = 9; tick();
        idle(); wv = 1; wt = 1; wval = 32'h77; tick();
        idle(); rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold", 32'(cflag), 32'd0);
        end
        rdy = 1; tick();
        chk("t6_c", 32'(cflag), 32'd1);
        chk("t6_V", cv, 32'h77);

        // async reset mid-run
        av = 1; tick(); tick();
        idle(); wv = 1; wt = 2; tick();
        idle(); tick();
        do_reset();
        chk("t7_tag", 32'(alloc_tag), 32'd1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rdy  = ($urandom_range(0, 9) != 0);
            av   = $urandom_range(0, 1);
            ard  = 5'($urandom);
            abr  = ($urandom_range(0, 3) == 0);
            apr  = $urandom_range(0, 1);
            wv   = ($urandom_range(0, 2) != 0);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                wt = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                wt = TAG_W'($urandom_range(0, DEPTH + 1));
            wval = $urandom;
            wtk  = $urandom_range(0, 1);
            wtg  = $urandom;
            q1   = TAG_W'($urandom_range(0, DEPTH));
            q2   = TAG_W'($urandom_range(0, DEPTH));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
